// File: rtl/odd_parity_checker_serial_if.sv
// Serial codeword link into the odd-parity checker, plus its decoded outputs.
// Widths follow the DATA_W / CNT_W parameters of the checker it is bound to.
interface odd_parity_checker_serial_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_sof;
  logic              in_bit;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              parity_err;
  logic              busy;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, in_sof, in_bit,
    input  out_valid, out_data, parity_err, busy, err_count
  );

  modport slave (
    input  in_valid, in_sof, in_bit,
    output out_valid, out_data, parity_err, busy, err_count
  );
endinterface

// File: rtl/odd_parity_checker_serial.sv
// Odd-parity serial checker: reassembles DATA_W data bits (MSB first) plus one
// parity bit and flags codewords whose total count of 1s is even.
// Optional feature macro: PARITY_ERR_COUNT_EN (saturating parity-error counter);
// when undefined err_count is tied to 0.
//
// state  | meaning
// IDLE   | waiting for in_sof; bits without sof are dropped
// DATA   | collecting data bits, bits_left counts the ones still owed
// PARITY | next valid non-sof bit is the parity bit
module odd_parity_checker_serial #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input logic                      clk,
  input logic                      rst,
  odd_parity_checker_serial_if.slave bus
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state;
  logic [CW-1:0]     bits_left;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              parity_err_q;
  logic              busy_q;

  logic [DATA_W:0]   sh_ext;
  logic              par_bad;
  logic              parity_take;

  assign sh_ext      = {shreg, bus.in_bit};
  // Total ones odd <=> acc ^ parity == 1, so an even total is the error case.
  assign par_bad     = ~(acc ^ bus.in_bit);
  assign parity_take = bus.in_valid && !bus.in_sof && (state == PARITY);

  // Frame FSM: sof always restarts a frame, even over a pending parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bits_left    <= '0;
      shreg        <= '0;
      acc          <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_sof) begin
          shreg     <= DATA_W'(bus.in_bit);
          acc       <= bus.in_bit;
          bits_left <= CW'(DATA_W - 1);
          state     <= (DATA_W == 1) ? PARITY : DATA;
          busy_q    <= 1'b1;
        end else begin
          unique case (state)
            IDLE: begin
            end
            DATA: begin
              shreg     <= sh_ext[DATA_W-1:0];
              acc       <= acc ^ bus.in_bit;
              bits_left <= bits_left - CW'(1);
              if (bits_left == CW'(1)) state <= PARITY;
            end
            PARITY: begin
              out_valid_q  <= 1'b1;
              out_data_q   <= shreg;
              parity_err_q <= par_bad;
              state        <= IDLE;
              busy_q       <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = busy_q;

`ifdef PARITY_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q;

  // Saturating count of bad frames, updated on the same edge as out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (parity_take && par_bad && !(&err_count_q)) begin
      err_count_q <= err_count_q + CNT_W'(1);
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = '0;
`endif

endmodule
